ram: RTL and testbench

- General-purpose 256 x 8 data RAM for the 8-bit CPU datapath.
- Reads are combinational: the selected word appears on `data` as soon as `address` changes.
- Writes are synchronous and occur on the rising clock edge while `write` is asserted.
- Asynchronous active-low reset clears every location to 0x00.

---
 rtl/ram.sv | 59 +++++
 tb/tb_ram.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ram.sv
`default_nettype none
// ============================================================================
//  Module      : ram
//  Description : 256 x 8 general-purpose data RAM for the 8-bit CPU datapath.
//                Combinational read, synchronous write, asynchronous clear of
//                the whole array on an active-low reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] data,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] write_data
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    // Implemented as a flop array so every word can be cleared asynchronously.
    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

    // One-hot write select, decoded independently of the read mux.
    logic [c_DEPTH-1:0]    w_word_sel;

    // Write-address decode: a word is selected only while write is asserted.
    always_comb begin
        w_word_sel = '0;
        for (int i = 0; i < c_DEPTH; i++) begin
            w_word_sel[i] = write && (address == ADDR_WIDTH'(i));
        end
    end

    // Storage: reset clears every word; otherwise only the selected word loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < c_DEPTH; i++) begin
                if (w_word_sel[i]) begin
                    r_mem[i] <= write_data;
                end
            end
        end
    end

    // Read mux: zero-latency, always driven. Old contents are visible until the
    // enabling edge updates the array; there is no write-first bypass.
    always_comb begin
        data = r_mem[address];
    end

endmodule
`default_nettype wire

// File: tb/tb_ram.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram
//  Description : Self-checking bench for ram: directed vector table, a few
//                hand-written multi-cycle sequences and randomized traffic
//                checked against an array model of the memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram;

    localparam int c_AW    = 8;
    localparam int c_DW    = 8;
    localparam int c_DEPTH = 256;

    logic             clk;
    logic             rst_n;
    logic [c_AW-1:0]  address;
    logic [c_DW-1:0]  data;
    logic             write;
    logic [c_DW-1:0]  write_data;

    int n_checks;
    int n_fail;

    // Reference model: plain array of words, cleared on reset.
    logic [c_DW-1:0] model [c_DEPTH];

    typedef struct {
        logic [7:0] addr;
        logic       wr;
        logic [7:0] wdata;
        logic [7:0] exp_pre;
        logic [7:0] exp_post;
    } vec_t;

    vec_t vecs [14];

    ram #(
        .ADDR_WIDTH (c_AW),
        .DATA_WIDTH (c_DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .address    (address),
        .data       (data),
        .write      (write),
        .write_data (write_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive inputs just after the falling edge, then let them settle.
    task automatic drive(input logic [7:0] a, input logic w, input logic [7:0] d);
        @(negedge clk);
        address    = a;
        write      = w;
        write_data = d;
        #1;
    endtask

    // Advance past the next rising edge and update the model accordingly.
    task automatic step();
        @(posedge clk);
        if (rst_n && write) model[address] = write_data;
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < c_DEPTH; i++) model[i] = 8'h00;
    endtask

    // Read every address with write low and compare against the model.
    task automatic sweep(input string name);
        write = 1'b0;
        for (int i = 0; i < c_DEPTH; i++) begin
            address = 8'(i);
            #1;
            check(name, data, model[i]);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        address    = 8'h00;
        write      = 1'b0;
        write_data = 8'h00;
        model_clear();

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        address = 8'h5A; write = 1'b1; write_data = 8'hC3;
        @(posedge clk); #1;
        check("reset_write_ignored", data, 8'h00);
        write = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        sweep("reset_sweep");

        // ---------------- directed vector table ----------------
        vecs[0]  = '{8'hA0, 1'b1, 8'hBE, 8'h00, 8'hBE};
        vecs[1]  = '{8'hA0, 1'b0, 8'h00, 8'hBE, 8'hBE};
        vecs[2]  = '{8'hA1, 1'b1, 8'hEF, 8'h00, 8'hEF};
        vecs[3]  = '{8'hA0, 1'b0, 8'h00, 8'hBE, 8'hBE};
        vecs[4]  = '{8'h10, 1'b0, 8'h55, 8'h00, 8'h00};
        vecs[5]  = '{8'h10, 1'b0, 8'h55, 8'h00, 8'h00};
        vecs[6]  = '{8'h10, 1'b0, 8'h55, 8'h00, 8'h00};
        vecs[7]  = '{8'h00, 1'b1, 8'h11, 8'h00, 8'h11};
        vecs[8]  = '{8'hFF, 1'b1, 8'hFF, 8'h00, 8'hFF};
        vecs[9]  = '{8'h00, 1'b1, 8'h22, 8'h11, 8'h22};
        vecs[10] = '{8'hFF, 1'b0, 8'h00, 8'hFF, 8'hFF};
        vecs[11] = '{8'h00, 1'b0, 8'h00, 8'h22, 8'h22};
        vecs[12] = '{8'hA1, 1'b0, 8'h00, 8'hEF, 8'hEF};
        vecs[13] = '{8'h01, 1'b0, 8'h00, 8'h00, 8'h00};

        for (int v = 0; v < 14; v++) begin
            drive(vecs[v].addr, vecs[v].wr, vecs[v].wdata);
            check($sformatf("vec%0d_pre", v), data, vecs[v].exp_pre);
            step();
            check($sformatf("vec%0d_post", v), data, vecs[v].exp_post);
        end
        sweep("directed_sweep");

        // ---------------- held write, moving address ----------------
        drive(8'h20, 1'b1, 8'h01); step();
        drive(8'h21, 1'b1, 8'h02); step();
        drive(8'h22, 1'b1, 8'h03); step();
        // Held write, constant address and data: idempotent rewrite.
        drive(8'h22, 1'b1, 8'h03); step();
        check("held_same_addr", data, 8'h03);
        drive(8'h20, 1'b0, 8'h00);
        check("held_addr20", data, 8'h01);
        address = 8'h21; #1;
        check("held_addr21", data, 8'h02);

        // ---------------- async reset mid-operation ----------------
        drive(8'h30, 1'b1, 8'h77);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        check("async_clear_a30", data, 8'h00);
        address = 8'hA0; #1;
        check("async_clear_a0", data, 8'hA0 & 8'h00);
        address = 8'h30;
        step();
        check("async_write_blocked", data, 8'h00);
        step();
        check("async_write_blocked2", data, 8'h00);
        // Release between edges while write stays high; next edge writes.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_pre_edge", data, 8'h00);
        step();
        check("release_first_write", data, 8'h77);
        write = 1'b0;
        sweep("post_reset_sweep");

        // ---------------- randomized traffic vs model ----------------
        for (int k = 0; k < 400; k++) begin
            logic [7:0] a;
            logic       w;
            logic [7:0] d;
            a = 8'($urandom_range(0, 255));
            if (k % 4 == 0) a = 8'($urandom_range(0, 7));   // concentrate on a few words
            w = ($urandom_range(0, 99) < 50);
            d = 8'($urandom);
            drive(a, w, d);
            check("rand_pre", data, model[a]);
            step();
            check("rand_post", data, model[a]);
        end
        sweep("final_sweep");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
